// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for the RISC-V core.
// Executes CSRRW/CSRRS/CSRRC read-modify-write, enforces privilege, read-only
// and WARL rules, sequences trap entry and mret with a registered redirect,
// and keeps 64-bit mcycle/minstret counters for XLEN = 32 or 64.
// Optional feature macro: CSR_INSTRET_EN builds minstret (and minstreth when
// XLEN = 32); without it those addresses are unimplemented and instret_i is
// ignored.
// XLEN must be 32 or 64.

module csr_file #(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr_i,
  input  logic [1:0]      csr_op_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            exc_valid_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_i,
  input  logic            instret_i,
  output logic            trap_redirect_o,
  output logic [XLEN-1:0] trap_pc_o,
  output logic [1:0]      priv_mode_o
);

  localparam logic [11:0] A_MSTATUS    = 12'h300;
  localparam logic [11:0] A_MISA       = 12'h301;
  localparam logic [11:0] A_MTVEC      = 12'h305;
  localparam logic [11:0] A_MSCRATCH   = 12'h340;
  localparam logic [11:0] A_MEPC       = 12'h341;
  localparam logic [11:0] A_MCAUSE     = 12'h342;
  localparam logic [11:0] A_MTVAL      = 12'h343;
  localparam logic [11:0] A_MCYCLE     = 12'hB00;
  localparam logic [11:0] A_MINSTRET   = 12'hB02;
  localparam logic [11:0] A_MCYCLEH    = 12'hB80;
  localparam logic [11:0] A_MINSTRETH  = 12'hB82;
  localparam logic [11:0] A_MVENDORID  = 12'hF11;
  localparam logic [11:0] A_MARCHID    = 12'hF12;
  localparam logic [11:0] A_MIMPID     = 12'hF13;
  localparam logic [11:0] A_MHARTID    = 12'hF14;
  localparam logic [11:0] A_MCONFIGPTR = 12'hF15;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam bit IS32 = (XLEN == 32);

  // MXL in the top two bits (1 = RV32, 2 = RV64) plus the I extension bit.
  localparam logic [XLEN-1:0] MISA_VAL =
    ((IS32 ? XLEN'(1) : XLEN'(2)) << (XLEN - 2)) | XLEN'(32'h100);

  // "AK" in ASCII
  localparam logic [XLEN-1:0] MIMPID_VAL = XLEN'(16'h414B);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic [XLEN-1:0] mscratch;
  logic            mie;
  logic            mpie;
  logic [1:0]      mpp;
  logic [1:0]      priv;
  logic            redirect;

  logic [63:0]     mcycle;
  logic [63:0]     mcycle_nxt;

  logic [XLEN-1:0] rd;
  logic [XLEN-1:0] wval;
  logic            hit;
  logic            write_req;
  logic            illegal;
  logic            csr_we;

`ifdef CSR_INSTRET_EN
  logic [63:0]     minstret;
  logic [63:0]     minstret_nxt;
`else
  logic            unused_instret;
  assign unused_instret = instret_i;
`endif

  // Read mux: current value of the addressed CSR and whether it exists.
  always_comb begin
    rd  = '0;
    hit = 1'b0;
    case (csr_addr_i)
      A_MISA:       begin hit = 1'b1; rd = MISA_VAL;    end
      A_MVENDORID:  begin hit = 1'b1; rd = '0;          end
      A_MARCHID:    begin hit = 1'b1; rd = XLEN'(100);  end
      A_MIMPID:     begin hit = 1'b1; rd = MIMPID_VAL;  end
      A_MHARTID:    begin hit = 1'b1; rd = HART_ID;     end
      A_MCONFIGPTR: begin hit = 1'b1; rd = '0;          end
      A_MSTATUS: begin
        hit = 1'b1;
        rd  = XLEN'({mpp, 3'b000, mpie, 3'b000, mie, 3'b000});
      end
      A_MTVEC:      begin hit = 1'b1; rd = mtvec;       end
      A_MEPC:       begin hit = 1'b1; rd = mepc;        end
      A_MCAUSE:     begin hit = 1'b1; rd = mcause;      end
      A_MTVAL:      begin hit = 1'b1; rd = mtval;       end
      A_MSCRATCH:   begin hit = 1'b1; rd = mscratch;    end
      A_MCYCLE:     begin hit = 1'b1; rd = mcycle[XLEN-1:0]; end
      A_MCYCLEH: begin
        if (IS32) begin
          hit = 1'b1;
          rd  = XLEN'(mcycle[63:32]);
        end
      end
`ifdef CSR_INSTRET_EN
      A_MINSTRET:   begin hit = 1'b1; rd = minstret[XLEN-1:0]; end
      A_MINSTRETH: begin
        if (IS32) begin
          hit = 1'b1;
          rd  = XLEN'(minstret[63:32]);
        end
      end
`endif
      default: ;
    endcase
  end

  // Access legality and the read-modify-write value.
  always_comb begin
    // RS/RC with a zero operand is a pure read, so read-only CSRs accept it.
    write_req = (csr_op_i == OP_RW) ||
                ((csr_op_i != OP_NONE) && (csr_wdata_i != '0));
    illegal   = !hit ||
                (write_req && (csr_addr_i[11:10] == 2'b11)) ||
                ((priv == PRIV_U) && (csr_addr_i[9:8] == 2'b11));
    // Traps and mret own the edge; a concurrent CSR write is dropped.
    csr_we    = write_req && !illegal && !exc_valid_i && !mret_i;
    case (csr_op_i)
      OP_RS:   wval = rd | csr_wdata_i;
      OP_RC:   wval = rd & ~csr_wdata_i;
      default: wval = csr_wdata_i;
    endcase
  end

  assign csr_illegal_o = (csr_op_i != OP_NONE) && illegal;
  assign csr_rdata_o   = illegal ? '0 : rd;
  assign priv_mode_o   = priv;
  // Masked by rst so a reset in the cycle after a trap swallows the pulse.
  assign trap_redirect_o = redirect && !rst;

  // Trap entry, mret and CSR writes in that priority order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtvec     <= RESET_MTVEC & ALIGN_MASK;
      mepc      <= '0;
      mcause    <= '0;
      mtval     <= '0;
      mscratch  <= '0;
      mie       <= 1'b0;
      mpie      <= 1'b0;
      mpp       <= PRIV_U;
      priv      <= PRIV_M;
      redirect  <= 1'b0;
      trap_pc_o <= '0;
    end else begin
      redirect <= 1'b0;
      if (exc_valid_i) begin
        mepc      <= exc_pc_i & ALIGN_MASK;
        mcause    <= exc_cause_i;
        mtval     <= exc_tval_i;
        mpie      <= mie;
        mie       <= 1'b0;
        mpp       <= priv;
        priv      <= PRIV_M;
        redirect  <= 1'b1;
        trap_pc_o <= mtvec;
      end else if (mret_i) begin
        mie       <= mpie;
        mpie      <= 1'b1;
        priv      <= mpp;
        mpp       <= PRIV_U;
        redirect  <= 1'b1;
        trap_pc_o <= mepc;
      end else if (csr_we) begin
        case (csr_addr_i)
          A_MSTATUS: begin
            mie  <= wval[3];
            mpie <= wval[7];
            // MPP is WARL: only U and M are legal, anything else keeps it.
            if ((wval[12:11] == PRIV_U) || (wval[12:11] == PRIV_M))
              mpp <= wval[12:11];
          end
          A_MTVEC:    mtvec    <= wval & ALIGN_MASK;
          A_MEPC:     mepc     <= wval & ALIGN_MASK;
          A_MCAUSE:   mcause   <= wval;
          A_MTVAL:    mtval    <= wval;
          A_MSCRATCH: mscratch <= wval;
          default: ;
        endcase
      end
    end
  end

  // Next cycle count: a write loads one half and holds the other, else count.
  always_comb begin
    mcycle_nxt = mcycle + 64'd1;
    if (csr_we && (csr_addr_i == A_MCYCLE)) begin
      if (IS32) mcycle_nxt = {mcycle[63:32], wval[31:0]};
      else      mcycle_nxt = 64'(wval);
    end else if (csr_we && IS32 && (csr_addr_i == A_MCYCLEH)) begin
      mcycle_nxt = {wval[31:0], mcycle[31:0]};
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) mcycle <= '0;
    else     mcycle <= mcycle_nxt;
  end

`ifdef CSR_INSTRET_EN
  // Next retired count, with the same half-write rules as mcycle.
  always_comb begin
    minstret_nxt = instret_i ? (minstret + 64'd1) : minstret;
    if (csr_we && (csr_addr_i == A_MINSTRET)) begin
      if (IS32) minstret_nxt = {minstret[63:32], wval[31:0]};
      else      minstret_nxt = 64'(wval);
    end else if (csr_we && IS32 && (csr_addr_i == A_MINSTRETH)) begin
      minstret_nxt = {wval[31:0], minstret[31:0]};
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk) begin
    if (rst) minstret <= '0;
    else     minstret <= minstret_nxt;
  end
`endif

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: a 64-bit instance for the CSR/trap behaviour
// and a 32-bit instance for the split counters.
module tb_csr_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 64-bit instance
  logic        rst;
  logic [11:0] addr;
  logic [1:0]  op;
  logic [63:0] wdata, rdata;
  logic        ill;
  logic        exc_valid, mret, instret;
  logic [63:0] exc_cause, exc_pc, exc_tval;
  logic        redir;
  logic [63:0] tpc;
  logic [1:0]  priv;

  // 32-bit instance
  logic        rst32;
  logic [11:0] addr32;
  logic [1:0]  op32;
  logic [31:0] wdata32, rdata32;
  logic        ill32;
  logic        exc_valid32, mret32, instret32;
  logic [31:0] exc_cause32, exc_pc32, exc_tval32;
  logic        redir32;
  logic [31:0] tpc32;
  logic [1:0]  priv32;

  csr_file #(.XLEN(64), .RESET_MTVEC(64'h200), .HART_ID(64'd5)) u_dut (
    .clk(clk), .rst(rst), .csr_addr_i(addr), .csr_op_i(op),
    .csr_wdata_i(wdata), .csr_rdata_o(rdata), .csr_illegal_o(ill),
    .exc_valid_i(exc_valid), .exc_cause_i(exc_cause), .exc_pc_i(exc_pc),
    .exc_tval_i(exc_tval), .mret_i(mret), .instret_i(instret),
    .trap_redirect_o(redir), .trap_pc_o(tpc), .priv_mode_o(priv));

  csr_file #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst32), .csr_addr_i(addr32), .csr_op_i(op32),
    .csr_wdata_i(wdata32), .csr_rdata_o(rdata32), .csr_illegal_o(ill32),
    .exc_valid_i(exc_valid32), .exc_cause_i(exc_cause32), .exc_pc_i(exc_pc32),
    .exc_tval_i(exc_tval32), .mret_i(mret32), .instret_i(instret32),
    .trap_redirect_o(redir32), .trap_pc_o(tpc32), .priv_mode_o(priv32));

  int n_checks = 0;
  int n_fail   = 0;

  // Expected responses: per access (rdata, illegal, priv) and per redirect.
  logic [63:0] erd_q[$];
  logic        eill_q[$];
  logic [1:0]  epr_q[$];
  string       enm_q[$];
  logic [63:0] erd32_q[$];
  logic        eill32_q[$];
  logic [1:0]  epr32_q[$];
  string       enm32_q[$];
  logic [63:0] etpc_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor for the 64-bit instance: accesses and redirect pulses.
  always @(negedge clk) begin
    if (op != 2'b00) begin
      if (erd_q.size() == 0) check("unexpected_access64", 64'(op), 64'd0);
      else begin
        string nm;
        nm = enm_q.pop_front();
        check({nm, "_rdata"}, rdata, erd_q.pop_front());
        check({nm, "_illegal"}, 64'(ill), 64'(eill_q.pop_front()));
        check({nm, "_priv"}, 64'(priv), 64'(epr_q.pop_front()));
      end
    end
    if (redir) begin
      if (etpc_q.size() == 0) check("unexpected_redirect", 64'(redir), 64'd0);
      else check("trap_pc", tpc, etpc_q.pop_front());
    end
  end

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (op32 != 2'b00) begin
      if (erd32_q.size() == 0) check("unexpected_access32", 64'(op32), 64'd0);
      else begin
        string nm;
        nm = enm32_q.pop_front();
        check({nm, "_rdata"}, 64'(rdata32), erd32_q.pop_front());
        check({nm, "_illegal"}, 64'(ill32), 64'(eill32_q.pop_front()));
        check({nm, "_priv"}, 64'(priv32), 64'(epr32_q.pop_front()));
      end
    end
    if (redir32) check("unexpected_redirect32", 64'(redir32), 64'd0);
  end

  task automatic acc64(input logic [1:0] o, input logic [11:0] a, input logic [63:0] wd,
                       input string nm, input logic [63:0] e_rd, input logic e_ill,
                       input logic [1:0] e_pr);
    erd_q.push_back(e_rd); eill_q.push_back(e_ill); epr_q.push_back(e_pr); enm_q.push_back(nm);
    op = o; addr = a; wdata = wd;
    @(posedge clk); #1;
    op = 2'b00; wdata = '0;
  endtask

  task automatic acc32(input logic [1:0] o, input logic [11:0] a, input logic [31:0] wd,
                       input string nm, input logic [63:0] e_rd, input logic e_ill);
    erd32_q.push_back(e_rd); eill32_q.push_back(e_ill); epr32_q.push_back(2'b11);
    enm32_q.push_back(nm);
    op32 = o; addr32 = a; wdata32 = wd;
    @(posedge clk); #1;
    op32 = 2'b00; wdata32 = '0;
  endtask

  task automatic trap64(input logic [63:0] pc, input logic [63:0] cause,
                        input logic [63:0] tval, input logic [63:0] exp_tpc);
    etpc_q.push_back(exp_tpc);
    exc_valid = 1'b1; exc_pc = pc; exc_cause = cause; exc_tval = tval;
    @(posedge clk); #1;
    exc_valid = 1'b0;
  endtask

  localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;

  initial begin
    rst = 1'b1; rst32 = 1'b1;
    op = '0; addr = '0; wdata = '0; exc_valid = 0; mret = 0; instret = 0;
    exc_cause = '0; exc_pc = '0; exc_tval = '0;
    op32 = '0; addr32 = '0; wdata32 = '0; exc_valid32 = 0; mret32 = 0; instret32 = 0;
    exc_cause32 = '0; exc_pc32 = '0; exc_tval32 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_redirect", 64'(redir), 64'd0);
    check("rst_trap_pc", tpc, 64'd0);
    check("rst_priv", 64'(priv), 64'd3);
    rst = 1'b0;

    // reset values and read-only identity registers
    acc64(RS, 12'h301, 0, "misa", 64'h8000_0000_0000_0100, 0, 2'b11);
    acc64(RS, 12'h305, 0, "mtvec_rst", 64'h200, 0, 2'b11);
    acc64(RS, 12'hF14, 0, "mhartid", 64'd5, 0, 2'b11);
    acc64(RS, 12'hF12, 0, "marchid", 64'd100, 0, 2'b11);
    acc64(RS, 12'hF13, 0, "mimpid", 64'h414B, 0, 2'b11);
    acc64(RS, 12'hF11, 0, "mvendorid", 64'd0, 0, 2'b11);
    acc64(RS, 12'h300, 0, "mstatus_rst", 64'd0, 0, 2'b11);

    // read-modify-write on mscratch
    acc64(RS, 12'h340, 0, "mscratch_rst", 64'd0, 0, 2'b11);
    acc64(RW, 12'h340, 64'hF0, "mscratch_rw", 64'd0, 0, 2'b11);
    acc64(RS, 12'h340, 0, "mscratch_rd1", 64'hF0, 0, 2'b11);
    acc64(RS, 12'h340, 64'h0F, "mscratch_rs", 64'hF0, 0, 2'b11);
    acc64(RS, 12'h340, 0, "mscratch_rd2", 64'hFF, 0, 2'b11);
    acc64(RC, 12'h340, 64'h3, "mscratch_rc", 64'hFF, 0, 2'b11);
    acc64(RS, 12'h340, 0, "mscratch_rd3", 64'hFC, 0, 2'b11);

    // read-only and unimplemented addresses
    acc64(RW, 12'hF14, 64'd1, "mhartid_wr", 64'd0, 1, 2'b11);
    acc64(RS, 12'hF14, 0, "mhartid_rs0", 64'd5, 0, 2'b11);
    acc64(RC, 12'hF14, 0, "mhartid_rc0", 64'd5, 0, 2'b11);
    acc64(RS, 12'h7C0, 0, "unimpl", 64'd0, 1, 2'b11);
    acc64(RS, 12'hB82, 0, "minstreth64", 64'd0, 1, 2'b11);
    acc64(RS, 12'hC00, 0, "cycle_shadow", 64'd0, 1, 2'b11);

    // mtvec alignment, MIE set, then a trap
    acc64(RW, 12'h305, 64'h103, "mtvec_wr", 64'h200, 0, 2'b11);
    acc64(RS, 12'h305, 0, "mtvec_rd", 64'h100, 0, 2'b11);
    acc64(RW, 12'h300, 64'h8, "mstatus_mie", 64'd0, 0, 2'b11);
    acc64(RS, 12'h300, 0, "mstatus_rd1", 64'h8, 0, 2'b11);
    trap64(64'h1002, 64'd2, 64'hDEAD, 64'h100);
    acc64(RS, 12'h341, 0, "mepc_trap", 64'h1000, 0, 2'b11);
    acc64(RS, 12'h342, 0, "mcause_trap", 64'd2, 0, 2'b11);
    acc64(RS, 12'h343, 0, "mtval_trap", 64'hDEAD, 0, 2'b11);
    acc64(RS, 12'h300, 0, "mstatus_trap", 64'h1880, 0, 2'b11);

    // MPP WARL
    acc64(RW, 12'h300, 64'h0808, "mstatus_warl", 64'h1880, 0, 2'b11);
    acc64(RS, 12'h300, 0, "mstatus_rd3", 64'h1808, 0, 2'b11);
    acc64(RC, 12'h300, 64'h1800, "mstatus_mpp0", 64'h1808, 0, 2'b11);
    acc64(RS, 12'h300, 64'h1000, "mstatus_rs_mpp2", 64'h8, 0, 2'b11);
    acc64(RS, 12'h300, 0, "mstatus_rd4", 64'h8, 0, 2'b11);

    // mret to U, then U-mode accesses to machine CSRs
    etpc_q.push_back(64'h1000);
    mret = 1'b1;
    @(posedge clk); #1;
    mret = 1'b0;
    acc64(RS, 12'h340, 0, "u_mscratch_rd", 64'd0, 1, 2'b00);
    acc64(RW, 12'h340, 64'h55, "u_mscratch_wr", 64'd0, 1, 2'b00);
    acc64(RS, 12'h305, 0, "u_mtvec_rd", 64'd0, 1, 2'b00);
    trap64(64'h2000, 64'd8, 64'd0, 64'h100);
    acc64(RS, 12'h340, 0, "mscratch_after_u", 64'hFC, 0, 2'b11);
    acc64(RS, 12'h300, 0, "mstatus_after_u", 64'd0, 0, 2'b11);
    acc64(RS, 12'h341, 0, "mepc2", 64'h2000, 0, 2'b11);

    // trap, mret and a CSR write on the same edge: trap wins
    exc_pc = 64'h3003; exc_cause = 64'd11; exc_tval = 64'd7;
    exc_valid = 1'b1; mret = 1'b1;
    etpc_q.push_back(64'h100);
    acc64(RW, 12'h340, 64'h1234, "prio_wr", 64'hFC, 0, 2'b11);
    exc_valid = 1'b0; mret = 1'b0;
    acc64(RS, 12'h340, 0, "mscratch_prio", 64'hFC, 0, 2'b11);
    acc64(RS, 12'h341, 0, "mepc_prio", 64'h3000, 0, 2'b11);
    acc64(RS, 12'h342, 0, "mcause_prio", 64'd11, 0, 2'b11);
    acc64(RS, 12'h300, 0, "mstatus_prio", 64'h1800, 0, 2'b11);

    // back-to-back traps give back-to-back pulses
    trap64(64'h4000, 64'd3, 64'd0, 64'h100);
    trap64(64'h5000, 64'd4, 64'd0, 64'h100);
    acc64(RS, 12'h341, 0, "mepc_b2b", 64'h5000, 0, 2'b11);

    // reset right after a trap swallows the redirect
    exc_valid = 1'b1; exc_pc = 64'h6000;
    @(posedge clk); #1;
    exc_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2_trap_pc", tpc, 64'd0);
    check("rst2_priv", 64'(priv), 64'd3);

    // 64-bit mcycle wrap; counter is zero in the first cycle after reset
    acc64(RW, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, "mcycle_wr", 64'd0, 0, 2'b11);
    acc64(RS, 12'hB00, 0, "mcycle_max", 64'hFFFF_FFFF_FFFF_FFFF, 0, 2'b11);
    acc64(RS, 12'hB00, 0, "mcycle_wrap", 64'd0, 0, 2'b11);
    acc64(RS, 12'hB00, 0, "mcycle_inc", 64'd1, 0, 2'b11);
    acc64(RS, 12'h305, 0, "mtvec_rst2", 64'h200, 0, 2'b11);
    acc64(RS, 12'h340, 0, "mscratch_rst2", 64'd0, 0, 2'b11);
    acc64(RS, 12'h341, 0, "mepc_rst2", 64'd0, 0, 2'b11);
    acc64(RW, 12'h341, 64'h1237, "mepc_wr", 64'd0, 0, 2'b11);
    acc64(RS, 12'h341, 0, "mepc_align", 64'h1234, 0, 2'b11);

    // 32-bit instance: split counters
    rst32 = 1'b0;
    acc32(RW, 12'hB00, 32'hFFFF_FFFF, "mcycle32_wr", 64'd0, 0);
    acc32(RW, 12'hB80, 32'd0, "mcycleh32_wr", 64'd0, 0);
    acc32(RS, 12'hB00, 0, "mcycle32_rd", 64'hFFFF_FFFF, 0);
    acc32(RS, 12'hB80, 0, "mcycleh32_carry", 64'd1, 0);
    acc32(RS, 12'hB00, 0, "mcycle32_rd2", 64'd1, 0);
    instret32 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    instret32 = 1'b0;
`ifdef CSR_INSTRET_EN
    acc32(RS, 12'hB02, 0, "minstret32", 64'd3, 0);
    acc32(RS, 12'hB82, 0, "minstreth32", 64'd0, 0);
`else
    acc32(RS, 12'hB02, 0, "minstret32_absent", 64'd0, 1);
    acc32(RS, 12'hB82, 0, "minstreth32_absent", 64'd0, 1);
`endif
    acc32(RW, 12'hC00, 32'd1, "cycle32_shadow", 64'd0, 1);
    acc32(RS, 12'h301, 0, "misa32", 64'h4000_0100, 0);
    acc32(RS, 12'h305, 0, "mtvec32_rst", 64'd0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("access_queue64_drained", 64'(erd_q.size()), 64'd0);
    check("access_queue32_drained", 64'(erd32_q.size()), 64'd0);
    check("redirect_queue_drained", 64'(etpc_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_file.md
# csr_file

Parametrised machine-mode CSR file for the fledgling RISC-V core; successor to the fixed RV64 CSR register bank. It executes CSRRW/CSRRS/CSRRC read-modify-write, enforces privilege, read-only and WARL rules, and runs trap entry/`mret` sequencing with a registered PC redirect. It maintains 64-bit cycle and retired-instruction counters for XLEN = 32 or 64. It sits beside the execute stage and drives the fetch redirect.

## Interface
- `XLEN`, 64, data width; only 32 or 64 legal.
- `RESET_MTVEC`, 0, `mtvec` value after reset; bits [1:0] must be 0.
- `HART_ID`, 0, value returned by `mhartid`.
- `clk` in 1: the single clock. All state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `csr_addr_i` in 12: CSR address.
- `csr_op_i` in 2: 00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits).
- `csr_wdata_i` in XLEN: operand (rs1 or zimm).
- `csr_rdata_o` out XLEN: old CSR value, combinational.
- `csr_illegal_o` out 1: combinational; asserted when the current access is illegal.
- `exc_valid_i` in 1: exception taken this cycle.
- `exc_cause_i` in XLEN: mcause value.
- `exc_pc_i` in XLEN: faulting PC.
- `exc_tval_i` in XLEN: trap value.
- `mret_i` in 1: `mret` retiring this cycle.
- `instret_i` in 1: one instruction retired this cycle.
- `trap_redirect_o` out 1: registered one-cycle pulse.
- `trap_pc_o` out XLEN: redirect target; valid only while `trap_redirect_o` = 1.
- `priv_mode_o` out 2: current privilege; 11 = M, 00 = U.

## Operation
- **Implemented registers**
  - Read-only: `misa` (MXL per XLEN, I bit), `mvendorid` 0, `marchid` 100, `mimpid` "AK", `mhartid` HART_ID, `mconfigptr` 0.
  - `mstatus`: MIE [3], MPIE [7], MPP [12:11].
  - `mtvec`: direct mode only; bits [1:0] read 0 and are ignored on write.
  - `mepc`: bits [1:0] forced to 0.
  - Plain read/write: `mscratch`, `mcause`, `mtval`.
  - Counters: `mcycle` 0xB00, `minstret` 0xB02. When XLEN = 32, `mcycleh` 0xB80 and `minstreth` 0xB82 hold the upper halves.
- **Write value**
  - RW writes `wdata`.
  - RS writes `old | wdata`.
  - RC writes `old & ~wdata`.
  - RS/RC with `wdata` == 0 perform no write and do not count as a write for the read-only check.
- **Illegal access**, any of:
  - unimplemented address;
  - a write to an address with `addr[11:10]` == 11;
  - `priv_mode_o` == U while `addr[9:8]` == 11.
- On an illegal access: no state change and `csr_rdata_o` = 0.
- **WARL, MPP:** only 00 and 11 are legal. A write of 01 or 10 keeps the previous MPP; the other written bits still apply. Unlisted `mstatus` bits read 0.
- **Trap entry** (`exc_valid_i`):
  - `mepc` ← `exc_pc_i` & ~3; `mcause` ← `exc_cause_i`; `mtval` ← `exc_tval_i`.
  - MPIE ← MIE; MIE ← 0; MPP ← current priv; priv ← M.
  - Next cycle: `trap_redirect_o` = 1 and `trap_pc_o` = `mtvec`.
- **mret** (`mret_i`):
  - MIE ← MPIE; MPIE ← 1; priv ← MPP; MPP ← 00.
  - Next cycle: `trap_redirect_o` = 1 and `trap_pc_o` = `mepc`.
- **Priority per edge:** `rst` > `exc_valid_i` > `mret_i` > CSR write. A CSR write that loses priority is dropped.
- **Counters**
  - 64-bit; `mcycle` increments every cycle, `minstret` increments on `instret_i`.
  - Both wrap from 2^64−1 to 0.
  - A CSR write to any counter half loads that half and suppresses the increment for that counter this cycle. The other half holds.
  - Exceptions do not stop the counters.

## Timing
- Reads are combinational, zero latency.
- A write is visible on `csr_rdata_o` the cycle after the edge.
- `trap_redirect_o` is exactly one cycle wide. Back-to-back exceptions give back-to-back pulses.
- Reset values:
  - `csr_rdata_o` follows the address (combinational).
  - `trap_redirect_o` = 0, `trap_pc_o` = 0, `priv_mode_o` = 11.
  - `mstatus` = 0, `mtvec` = RESET_MTVEC.
  - `mepc`, `mcause`, `mtval`, `mscratch` and both counters = 0.
- If `rst` is asserted in the cycle after an exception, no redirect pulse appears.

## Configuration
- `CSR_INSTRET_EN` defined: `minstret` (and `minstreth` when XLEN = 32) is implemented and counts as specified above.
- `CSR_INSTRET_EN` undefined:
  - the counter is not built;
  - 0xB02 and 0xB82 are unimplemented, so any access asserts `csr_illegal_o`;
  - `instret_i` is ignored.

## Test plan
- Reset, then read `misa` with XLEN = 64 → bits [63:62] = 10, bit 8 = 1; `priv_mode_o` = 11; `mtvec` = RESET_MTVEC.
- `mscratch`: RW 0xF0, then RS 0x0F, then RC 0x3 → reads 0xF0, then 0xFF, then 0xFC; RC returns old value 0xFF.
- `mstatus` MIE = 1, then exception (pc 0x1002, cause 2, tval 0xDEAD) with `mtvec` = 0x100:
  - next cycle: redirect pulse with `trap_pc_o` 0x100;
  - `mepc` 0x1000, `mcause` 2, `mtval` 0xDEAD, MIE 0, MPIE 1, MPP 11.
- Set MPP = 00, then `mret` → redirect to `mepc`, `priv_mode_o` = 00. A following read of 0x340 asserts `csr_illegal_o` and leaves state unchanged.
- Same-cycle exception + `mret` + RW to `mscratch` → trap entry only; `mscratch` unchanged.
- XLEN = 32, CSR_INSTRET_EN defined:
  - write `mcycle` = 0xFFFFFFFF, `mcycleh` = 0 → after one more cycle `mcycleh` reads 1;
  - `instret_i` held 3 cycles → `minstret` = 3;
  - write 0xC00 → illegal.
